dmem_access: RTL
================

Name: dmem_access

Overview:
- Pipeline stage between EX and MEM.
- Turns EX-stage load/store requests into word-aligned data-memory bus transactions with byte enables, using a req/ack handshake.
- Stalls the upstream pipeline while a transaction is outstanding.
- Registers the load data, lane-shifted to bit 0, plus the writeback fields into the MEM stage's inputs (raw_Data_in, dm_ctrl, bias, RegWrite_in, rd_in, WDSel_in, WD_in).

Parameters:
- ADDR_W, 32, byte-address width; mem_addr is ADDR_W bits.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- MemRead_in  in  1  EX instruction is a load.
- MemWrite_in  in  1  EX instruction is a store.
- dm_ctrl_in  in  3  access size/sign; uses the shared `dm_word/`dm_halfword/`dm_byte/`dm_halfword_unsigned/`dm_byte_unsigned defines.
- addr_in  in  ADDR_W  byte address (ALU result).
- wdata_in  in  32  store data (rs2).
- RegWrite_in  in  1  writeback enable from EX.
- rd_in  in  5  destination register.
- WDSel_in  in  2  writeback source select.
- WD_in  in  32  non-memory writeback value.
- mem_req  out  1  bus request, held until ack.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  {addr_in[ADDR_W-1:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-positioned store data.
- mem_ack  in  1  single-cycle completion.
- mem_rdata  in  32  read word, valid with mem_ack.
- stall  out  1  combinational; upstream holds all *_in stable while high.
- misalign  out  1  registered one-cycle pulse; access dropped.
- raw_Data  out  32  read word shifted right by 8*bias.
- dm_ctrl  out  3  registered dm_ctrl_in.
- bias  out  2  registered addr_in[1:0].
- RegWrite  out  1  registered writeback enable.
- rd  out  5  registered rd_in.
- WDSel  out  2  registered WDSel_in.
- WD  out  32  registered WD_in.

Behaviour:
- Reset, asynchronous, rst=0:
  - State goes to IDLE.
  - mem_req, mem_we, misalign, RegWrite are 0.
  - mem_be=4'b0; mem_addr, mem_wdata, raw_Data, WD are 0; rd, bias, dm_ctrl, WDSel are 0.
  - mem_req drops immediately, even mid-transaction.
  - The interrupted transaction is abandoned; a later stray mem_ack is ignored in IDLE.
- Misalignment: access = MemRead_in|MemWrite_in. An access is misaligned when:
  - word and addr_in[1:0]!=0, or
  - halfword (signed or unsigned) and addr_in[0]=1.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - halfword: 4'b0011<<addr[1:0].
  - word: 4'b1111.
  - loads drive the same byte enables.
- Store data: byte replicated to all four lanes; halfword replicated to both halves; word unchanged.
- FSM states IDLE and BUSY.
- IDLE, no access:
  - stall=0.
  - At the edge, all output registers capture the inputs (RegWrite<=RegWrite_in). Latency is 1 cycle.
- IDLE, misaligned access:
  - stall=0 and no bus request is made.
  - At the edge: misalign<=1, RegWrite<=0, other fields captured.
- IDLE, aligned access:
  - stall=1.
  - At the edge: go to BUSY; mem_req<=1; mem_we<=MemWrite_in; load mem_addr, mem_be, mem_wdata.
  - RegWrite<=0, i.e. a bubble goes to MEM.
- BUSY, mem_ack=0: stall=1, bus outputs held, RegWrite<=0 each edge.
- BUSY, mem_ack=1:
  - stall=0.
  - At the edge: raw_Data<=mem_rdata>>(8*addr_in[1:0]); other outputs captured from inputs; mem_req<=0, mem_we<=0; go to IDLE.
  - For stores, raw_Data is still captured (don't-care); RegWrite follows RegWrite_in.
- Minimum cost of a memory access is 1 stall cycle (ack in the first BUSY cycle).
- Back-to-back accesses: the next instruction arrives in IDLE and gets a new request one cycle later. mem_req is never asserted in two consecutive transactions without an IDLE cycle between them.
- misalign is cleared to 0 on every edge where it is not set.
- mem_ack is ignored in IDLE.
- MemRead_in and MemWrite_in both high is treated as a store.

Test Plan:
- Reset mid-BUSY, with mem_req=1 and rst pulled low between edges → mem_req=0, RegWrite=0 and state IDLE with no clock edge; an ack in the next cycle has no effect.
- ALU op (RegWrite_in=1, rd_in=5, WD_in=0x1234, no access) → next cycle RegWrite=1, rd=5, WD=0x1234, stall never high.
- lb at addr 0x103, mem_rdata=0xAB000000, ack in first BUSY cycle:
  - mem_addr=0x100, mem_be=4'b1000, stall high for exactly 1 cycle.
  - Then raw_Data=0x000000AB, bias=3, RegWrite=1.
- sh at 0x202, wdata_in=0xDEADBEEF, ack after 3 BUSY cycles:
  - mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEFBEEF, stall high 4 cycles.
  - RegWrite=0 for each of the 4 stall edges.
- lw at 0x105 → no mem_req, misalign=1 for exactly one cycle, RegWrite=0, stall=0.
- Back-to-back sw 0x0 then lw 0x4, each with immediate ack → two distinct mem_req pulses separated by one low cycle; the lw result reaches raw_Data 4 cycles after the sw was first presented.

Source files
------------

// File: rtl/dmem_access.sv
// EX->MEM data-memory access stage: one req/ack bus transaction per aligned load/store; result
// lands 1 cycle after ack (1 cycle for non-memory ops); stall is held high while a request is pending.
`ifndef DM_WORD
`define DM_WORD              3'b000
`define DM_HALFWORD          3'b001
`define DM_HALFWORD_UNSIGNED 3'b010
`define DM_BYTE              3'b011
`define DM_BYTE_UNSIGNED     3'b100
`endif

module dmem_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [2:0]        dm_ctrl_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       wdata_in,
  input  logic              RegWrite_in,
  input  logic [4:0]        rd_in,
  input  logic [1:0]        WDSel_in,
  input  logic [31:0]       WD_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              misalign,
  output logic [31:0]       raw_Data,
  output logic [2:0]        dm_ctrl,
  output logic [1:0]        bias,
  output logic              RegWrite,
  output logic [4:0]        rd,
  output logic [1:0]        WDSel,
  output logic [31:0]       WD
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic        access, is_byte, is_half, is_word, misal;
  logic        launch, done, misal_evt;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] rdata_sh;

  always_comb begin
    is_byte = (dm_ctrl_in == `DM_BYTE) || (dm_ctrl_in == `DM_BYTE_UNSIGNED);
    is_half = (dm_ctrl_in == `DM_HALFWORD) || (dm_ctrl_in == `DM_HALFWORD_UNSIGNED);
    is_word = !is_byte && !is_half;
    access  = MemRead_in | MemWrite_in;
    misal   = access && ((is_word && (addr_in[1:0] != 2'b00)) || (is_half && addr_in[0]));
    if (is_byte) begin
      be_n    = 4'b0001 << addr_in[1:0];
      wdata_n = {4{wdata_in[7:0]}};
    end else if (is_half) begin
      be_n    = 4'b0011 << addr_in[1:0];
      wdata_n = {2{wdata_in[15:0]}};
    end else begin
      be_n    = 4'b1111;
      wdata_n = wdata_in;
    end
    rdata_sh = mem_rdata >> {addr_in[1:0], 3'b000};
  end

  // mem_ack only matters in BUSY; a stray ack in IDLE falls through untouched
  always_comb begin
    state_n   = state;
    stall     = 1'b0;
    launch    = 1'b0;
    done      = 1'b0;
    misal_evt = 1'b0;
    case (state)
      IDLE: begin
        if (access && !misal) begin
          stall   = 1'b1;
          launch  = 1'b1;
          state_n = BUSY;
        end else begin
          misal_evt = misal;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Writeback fields track inputs every edge; upstream holds them stable while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0;
      mem_wdata <= 32'b0;
      misalign  <= 1'b0;
      raw_Data  <= 32'b0;
      dm_ctrl   <= 3'b0;
      bias      <= 2'b0;
      RegWrite  <= 1'b0;
      rd        <= 5'b0;
      WDSel     <= 2'b0;
      WD        <= 32'b0;
    end else begin
      dm_ctrl  <= dm_ctrl_in;
      bias     <= addr_in[1:0];
      rd       <= rd_in;
      WDSel    <= WDSel_in;
      WD       <= WD_in;
      misalign <= misal_evt;
      RegWrite <= (done || (state == IDLE && !access)) ? RegWrite_in : 1'b0;
      if (launch) begin
        mem_req   <= 1'b1;
        mem_we    <= MemWrite_in;
        mem_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
        mem_be    <= be_n;
        mem_wdata <= wdata_n;
      end
      if (done) begin
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        raw_Data <= rdata_sh;
      end
    end
  end

endmodule
